mux_n_1_arb: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking on every input channel and on the output. It is the successor to the fixed 8:1 combinational mux in the datapath-components set. It selects one source per cycle, either by an externally driven select code (fixed mode) or by round-robin arbitration. The selected beat is captured into a one-entry output register that downstream logic drains with back-pressure.

---
 rtl/mux_n_1_arb_if.sv | 30 +++
 rtl/mux_n_1_arb.sv | 111 +++++++++++
 tb/tb_mux_n_1_arb.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_n_1_arb_if.sv
// Handshake/bus bundle for mux_n_1_arb.
// Ports: i_mode/i_sel_code select the source, i_code/i_valid carry N_CH input channels,
//        o_ready is the per-channel accept, o_f/o_sel_code/o_valid/i_ready form the output handshake.
interface mux_n_1_arb_if #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
);
  logic                  i_mode;
  logic [SEL_W-1:0]      i_sel_code;
  logic [N_CH*WIDTH-1:0] i_code;
  logic [N_CH-1:0]       i_valid;
  logic [N_CH-1:0]       o_ready;
  logic [WIDTH-1:0]      o_f;
  logic [SEL_W-1:0]      o_sel_code;
  logic                  o_valid;
  logic                  i_ready;

  // Mux side: consumes selects/channels/downstream ready, produces accepts and the output beat.
  modport slave (
    input  i_mode, i_sel_code, i_code, i_valid, i_ready,
    output o_ready, o_f, o_sel_code, o_valid
  );

  // Environment side: the mirror image.
  modport master (
    output i_mode, i_sel_code, i_code, i_valid, i_ready,
    input  o_ready, o_f, o_sel_code, o_valid
  );
endinterface

// File: rtl/mux_n_1_arb.sv
// N-channel registered mux with fixed-select or round-robin grant into a one-entry output stage.
// Latency: a transfer at edge n is visible on o_f/o_sel_code/o_valid right after edge n.
// Backpressure: o_ready only asserts when the stage is empty or draining this cycle (load_en).
// Ports: i_clk, i_rst (async active-high) plain; everything else through mux_n_1_arb_if.slave.
module mux_n_1_arb #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mux_n_1_arb_if.slave  bus
);
  localparam int SEL_W = $clog2(N_CH);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] rr_idx;
  logic [WIDTH-1:0] grant_dat;
  logic             load_en;
  logic             xfer;

  // Grant evaluation. Fixed mode compares against every legal index, so an
  // out-of-range select code simply matches nothing.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    if (!bus.i_mode) begin
      for (int k = 0; k < N_CH; k++) begin
        if (bus.i_sel_code == SEL_W'(k) && bus.i_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(k);
        end
      end
    end else begin
      // Search starts one past the last round-robin winner and wraps.
      for (int k = 1; k <= N_CH; k++) begin
        rr_idx = SEL_W'((int'(rr_ptr_q) + k) % N_CH);
        if (!grant_vld && bus.i_valid[rr_idx]) begin
          grant_vld = 1'b1;
          grant_idx = rr_idx;
        end
      end
    end
  end

  always_comb begin
    grant_dat = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        grant_dat = bus.i_code[k*WIDTH +: WIDTH];
      end
    end
  end

  assign load_en = (state_q == ST_EMPTY) || bus.i_ready;
  // No accept while reset is held, so a beat is never lost mid-reset.
  assign xfer    = load_en && grant_vld && !i_rst;

  always_comb begin
    bus.o_ready = '0;
    for (int k = 0; k < N_CH; k++) begin
      bus.o_ready[k] = xfer && (grant_idx == SEL_W'(k));
    end
  end

  always_comb begin
    state_d  = state_q;
    f_d      = f_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      state_d = ST_FULL;
      f_d     = grant_dat;
      sel_d   = grant_idx;
      if (bus.i_mode) begin
        rr_ptr_d = grant_idx;
      end
    end else if (state_q == ST_FULL && bus.i_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_EMPTY;
      f_q      <= '0;
      sel_q    <= '0;
      rr_ptr_q <= SEL_W'(N_CH - 1);
    end else begin
      state_q  <= state_d;
      f_q      <= f_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.o_f        = f_q;
  assign bus.o_sel_code = sel_q;
  assign bus.o_valid    = (state_q == ST_FULL);
endmodule

// File: tb/tb_mux_n_1_arb.sv
module tb_mux_n_1_arb;
  localparam int N = 8;
  localparam int W = 8;

  logic clk;
  logic rst;

  mux_n_1_arb_if #(.N_CH(N), .WIDTH(W)) bus ();

  mux_n_1_arb #(.N_CH(N), .WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: one holding slot plus the last round-robin winner.
  bit         m_valid;
  logic [7:0] m_f;
  int         m_sel;
  int         m_rr;

  function automatic int ref_grant();
    if (!bus.i_mode) begin
      if (int'(bus.i_sel_code) < N && bus.i_valid[bus.i_sel_code])
        return int'(bus.i_sel_code);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_rr + k) % N;
      if (bus.i_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] ref_ready();
    logic [7:0] r;
    int g;
    r = '0;
    g = ref_grant();
    if (!rst && (!m_valid || bus.i_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_f     = '0;
    m_sel   = 0;
    m_rr    = N - 1;
  endtask

  // Advance the model with the inputs present just before the edge, then move past the edge.
  task automatic tick();
    int g;
    if (rst) begin
      model_reset();
    end else begin
      g = ref_grant();
      if ((!m_valid || bus.i_ready) && g >= 0) begin
        m_valid = 1;
        m_f     = bus.i_code[g*W +: W];
        m_sel   = g;
        if (bus.i_mode) m_rr = g;
      end else if (m_valid && bus.i_ready) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp_codes();
    for (int k = 0; k < N; k++) bus.i_code[k*W +: W] = 8'(8'h10 + k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_mode = 1'b1;
    bus.i_sel_code = 3'd0;
    bus.i_valid = 8'hFF;
    bus.i_ready = 1'b1;
    set_ramp_codes();
    tick();
    tick();
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_f !== 8'h00) begin n_err++; $display("FAIL reset_o_f got %h want 00", bus.o_f); end
    n_cmp++; if (bus.o_sel_code !== 3'd0) begin n_err++; $display("FAIL reset_o_sel got %0d want 0", bus.o_sel_code); end
    n_cmp++; if (bus.o_ready !== 8'h00) begin n_err++; $display("FAIL reset_o_ready got %b want 0", bus.o_ready); end
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    bus.i_mode = 1'b0;
    bus.i_sel_code = 3'd5;
    bus.i_valid = 8'hFF;
    bus.i_ready = 1'b1;
    set_ramp_codes();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (bus.o_ready !== 8'b0010_0000) begin n_err++; $display("FAIL fixed_o_ready cyc %0d got %b want 00100000", i, bus.o_ready); end
      tick();
      n_cmp++; if (bus.o_f !== 8'h15) begin n_err++; $display("FAIL fixed_o_f cyc %0d got %h want 15", i, bus.o_f); end
      n_cmp++; if (bus.o_sel_code !== 3'd5) begin n_err++; $display("FAIL fixed_o_sel cyc %0d got %0d want 5", i, bus.o_sel_code); end
      n_cmp++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL fixed_o_valid cyc %0d got %b want 1", i, bus.o_valid); end
    end
  endtask

  task automatic test_rr_all();
    logic [7:0] exp_r;
    bus.i_mode = 1'b1;
    bus.i_valid = 8'hFF;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_r = 8'(1 << (i % N));
      n_cmp++; if (bus.o_ready !== exp_r) begin n_err++; $display("FAIL rr_all_o_ready cyc %0d got %b want %b", i, bus.o_ready, exp_r); end
      tick();
      n_cmp++; if (bus.o_sel_code !== 3'(i % N)) begin n_err++; $display("FAIL rr_all_o_sel cyc %0d got %0d want %0d", i, bus.o_sel_code, i % N); end
      n_cmp++; if (bus.o_f !== 8'(8'h10 + (i % N))) begin n_err++; $display("FAIL rr_all_o_f cyc %0d got %h want %h", i, bus.o_f, 8'(8'h10 + (i % N))); end
    end
  endtask

  task automatic test_rr_sparse();
    int e;
    bus.i_valid = 8'b1000_0100;
    for (int i = 0; i < 4; i++) begin
      e = (i % 2 == 0) ? 2 : 7;
      tick();
      n_cmp++; if (bus.o_sel_code !== 3'(e)) begin n_err++; $display("FAIL rr_sparse_o_sel cyc %0d got %0d want %0d", i, bus.o_sel_code, e); end
      n_cmp++; if (bus.o_f !== 8'(8'h10 + e)) begin n_err++; $display("FAIL rr_sparse_o_f cyc %0d got %h want %h", i, bus.o_f, 8'(8'h10 + e)); end
    end
  endtask

  task automatic test_backpressure();
    bus.i_mode = 1'b0;
    bus.i_sel_code = 3'd3;
    bus.i_valid = 8'h08;
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    bus.i_valid = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.o_ready !== 8'h00) begin n_err++; $display("FAIL bp_o_ready cyc %0d got %b want 0", i, bus.o_ready); end
      tick();
      n_cmp++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL bp_o_valid cyc %0d got %b want 1", i, bus.o_valid); end
      n_cmp++; if (bus.o_f !== 8'h13) begin n_err++; $display("FAIL bp_o_f cyc %0d got %h want 13", i, bus.o_f); end
      n_cmp++; if (bus.o_sel_code !== 3'd3) begin n_err++; $display("FAIL bp_o_sel cyc %0d got %0d want 3", i, bus.o_sel_code); end
    end
    bus.i_ready = 1'b1;
    bus.i_valid = 8'h00;
    tick();
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain_o_valid got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_f !== 8'h13) begin n_err++; $display("FAIL bp_drain_o_f got %h want 13", bus.o_f); end
  endtask

  task automatic test_mode_switch();
    bus.i_mode = 1'b1;
    bus.i_valid = 8'hFF;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 16 && m_rr != 3; i++) tick();
    n_cmp++; if (bus.o_sel_code !== 3'd3) begin n_err++; $display("FAIL ms_reach3 got %0d want 3", bus.o_sel_code); end
    bus.i_mode = 1'b0;
    bus.i_sel_code = 3'd6;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (bus.o_sel_code !== 3'd6) begin n_err++; $display("FAIL ms_fixed_o_sel beat %0d got %0d want 6", i, bus.o_sel_code); end
      n_cmp++; if (bus.o_f !== 8'h16) begin n_err++; $display("FAIL ms_fixed_o_f beat %0d got %h want 16", i, bus.o_f); end
    end
    bus.i_mode = 1'b1;
    tick();
    n_cmp++; if (bus.o_sel_code !== 3'd4) begin n_err++; $display("FAIL ms_resume_o_sel got %0d want 4", bus.o_sel_code); end
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL ms_async_rst_o_valid got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_ready !== 8'h00) begin n_err++; $display("FAIL ms_async_rst_o_ready got %b want 0", bus.o_ready); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.o_sel_code !== 3'd0) begin n_err++; $display("FAIL ms_post_rst_o_sel got %0d want 0", bus.o_sel_code); end
    n_cmp++; if (bus.o_f !== 8'h10) begin n_err++; $display("FAIL ms_post_rst_o_f got %h want 10", bus.o_f); end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_r;
    bus.i_mode = 1'b0;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 2048; c++) begin
      bus.i_valid = c[7:0];
      bus.i_sel_code = c[10:8];
      bus.i_code = {$urandom, $urandom};
      #1;
      exp_r = ref_ready();
      n_cmp++; if (bus.o_ready !== exp_r) begin n_err++; $display("FAIL sweep_o_ready combo %0d got %b want %b", c, bus.o_ready, exp_r); end
      tick();
      n_cmp++; if (bus.o_f !== m_f) begin n_err++; $display("FAIL sweep_o_f combo %0d got %h want %h", c, bus.o_f, m_f); end
      n_cmp++; if (bus.o_valid !== m_valid) begin n_err++; $display("FAIL sweep_o_valid combo %0d got %b want %b", c, bus.o_valid, m_valid); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_r;
    for (int i = 0; i < 600; i++) begin
      bus.i_mode = 1'($urandom_range(0, 1));
      bus.i_sel_code = 3'($urandom_range(0, 7));
      bus.i_valid = 8'($urandom);
      bus.i_ready = ($urandom_range(0, 3) != 0);
      bus.i_code = {$urandom, $urandom};
      #1;
      exp_r = ref_ready();
      n_cmp++; if (bus.o_ready !== exp_r) begin n_err++; $display("FAIL rand_o_ready cyc %0d got %b want %b", i, bus.o_ready, exp_r); end
      tick();
      n_cmp++; if (bus.o_valid !== m_valid) begin n_err++; $display("FAIL rand_o_valid cyc %0d got %b want %b", i, bus.o_valid, m_valid); end
      n_cmp++; if (bus.o_f !== m_f) begin n_err++; $display("FAIL rand_o_f cyc %0d got %h want %h", i, bus.o_f, m_f); end
      n_cmp++; if (bus.o_sel_code !== 3'(m_sel)) begin n_err++; $display("FAIL rand_o_sel cyc %0d got %0d want %0d", i, bus.o_sel_code, m_sel); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.i_mode = 1'b0;
    bus.i_sel_code = '0;
    bus.i_code = '0;
    bus.i_valid = '0;
    bus.i_ready = 1'b0;
    model_reset();
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_mode_switch();
    test_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
